pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 55 +++++
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/pipe_ctrl_decode.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode constants, the
// instruction class enum, the per-stage control bundle and its bubble value.
// No ports (package).
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RFMT = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LUI  = 6'd15;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    // Destination field width inside the bundle; REG_AW of the top must not
    // exceed it. Register numbers are zero-extended into this field.
    localparam int CTRL_AW = 8;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {RFMT, IFMT, LW, SW, BEQ, BNE, J, ILL} instr_class_e;

    typedef struct packed {
        logic [1:0]         alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic [CTRL_AW-1:0] wreg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic instr_class_e classify(input logic [5:0] op);
        instr_class_e c;
        case (op)
            OP_RFMT:                                 c = RFMT;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: c = IFMT;
            OP_LW:                                   c = LW;
            OP_SW:                                   c = SW;
            OP_BEQ:                                  c = BEQ;
            OP_BNE:                                  c = BNE;
            OP_J:                                    c = J;
            default:                                 c = ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the datapath and the pipeline control unit.
// master: datapath side (drives ID fields, receives control/counters).
// slave : control unit side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) ();
    logic [5:0]        opcode_id;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic [REG_AW-1:0] rd_id;
    logic              equal_id;
    logic              pc_write;
    logic              ifid_write;
    logic              if_flush;
    logic [1:0]        pc_sel;
    logic [1:0]        alu_op_ex;
    logic              alu_src_ex;
    logic              mem_read_ex;
    logic              reg_write_ex;
    logic [REG_AW-1:0] wreg_ex;
    logic              mem_read_mem;
    logic              mem_write_mem;
    logic              reg_write_mem;
    logic [REG_AW-1:0] wreg_mem;
    logic              reg_write_wb;
    logic              mem_to_reg_wb;
    logic [REG_AW-1:0] wreg_wb;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output opcode_id, rs_id, rt_id, rd_id, equal_id,
        input  pc_write, ifid_write, if_flush, pc_sel,
        input  alu_op_ex, alu_src_ex, mem_read_ex, reg_write_ex, wreg_ex,
        input  mem_read_mem, mem_write_mem, reg_write_mem, wreg_mem,
        input  reg_write_wb, mem_to_reg_wb, wreg_wb, stall_cnt, flush_cnt
    );

    modport slave (
        input  opcode_id, rs_id, rt_id, rd_id, equal_id,
        output pc_write, ifid_write, if_flush, pc_sel,
        output alu_op_ex, alu_src_ex, mem_read_ex, reg_write_ex, wreg_ex,
        output mem_read_mem, mem_write_mem, reg_write_mem, wreg_mem,
        output reg_write_wb, mem_to_reg_wb, wreg_wb, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decoder.
// i_opcode/i_rt/i_rd : ID instruction fields
// o_ctrl             : control bundle for the instruction
// o_use_rs/o_use_rt  : which register fields are read as sources
// o_class            : instruction class
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [5:0]        i_opcode,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_rd,
    output ctrl_t             o_ctrl,
    output logic              o_use_rs,
    output logic              o_use_rt,
    output instr_class_e      o_class
);

    always_comb begin
        o_ctrl   = CTRL_BUBBLE;
        o_use_rt = 1'b0;
        o_class  = classify(i_opcode);
        // Every instruction other than j reads rs.
        o_use_rs = (o_class != J);
        case (o_class)
            RFMT: begin
                o_ctrl.alu_op    = 2'b10;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wreg      = CTRL_AW'(i_rd);
                o_use_rt         = 1'b1;
            end
            IFMT: begin
                o_ctrl.alu_op    = 2'b11;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wreg      = CTRL_AW'(i_rt);
            end
            LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.wreg       = CTRL_AW'(i_rt);
            end
            SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_use_rt         = 1'b1;
            end
            BEQ, BNE: begin
                o_ctrl.alu_op = 2'b01;
                o_use_rt      = 1'b1;
            end
            default: ;
        endcase
        // r0 is hardwired; writing it is a no-op.
        if (o_ctrl.wreg == '0) o_ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: decodes ID, carries control through ID/EX, EX/MEM
// and MEM/WB, detects load-use and branch-operand hazards, resolves
// beq/bne/j in ID with a multi-cycle fetch squash, and keeps saturating
// stall/flush counters.
// clk, reset : clock, synchronous active-high reset
// bus        : ID fields in; front-end control, stage control, counters out
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input logic          clk,
    input logic          reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int SQ_W = 2;

    ctrl_t            r_ex, r_mem, r_wb;
    logic [SQ_W-1:0]  r_sq, w_sq_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    ctrl_t            w_dec;
    logic             w_use_rs, w_use_rt;
    instr_class_e     w_class;
    logic [CTRL_AW-1:0] w_rs, w_rt;
    logic             w_is_br, w_load_use, w_br_haz, w_taken;
    logic             w_squash, w_stall, w_redirect, w_flush;

    pipe_ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .i_opcode (bus.opcode_id),
        .i_rt     (bus.rt_id),
        .i_rd     (bus.rd_id),
        .o_ctrl   (w_dec),
        .o_use_rs (w_use_rs),
        .o_use_rt (w_use_rt),
        .o_class  (w_class)
    );

    assign w_rs    = CTRL_AW'(bus.rs_id);
    assign w_rt    = CTRL_AW'(bus.rt_id);
    assign w_is_br = (w_class == BEQ) || (w_class == BNE);

    assign w_load_use = r_ex.mem_read && (r_ex.wreg != '0) &&
                        ((w_use_rs && (r_ex.wreg == w_rs)) ||
                         (w_use_rt && (r_ex.wreg == w_rt)));

    // Branches compare in ID, so an ALU result still in EX or a load in MEM
    // cannot be forwarded in time.
    assign w_br_haz = w_is_br &&
                      ((r_ex.reg_write && ((r_ex.wreg == w_rs) || (r_ex.wreg == w_rt))) ||
                       (r_mem.mem_read && ((r_mem.wreg == w_rs) || (r_mem.wreg == w_rt))));

    assign w_taken = ((w_class == BEQ) && bus.equal_id) ||
                     ((w_class == BNE) && !bus.equal_id) ||
                     (w_class == J);

    assign w_squash   = (r_sq != '0);
    assign w_stall    = !w_squash && (w_load_use || w_br_haz);
    assign w_redirect = !w_squash && !w_stall && w_taken;
    assign w_flush    = w_squash || w_redirect;

    always_comb begin
        w_sq_nxt = r_sq;
        if (w_redirect)    w_sq_nxt = SQ_W'(BRANCH_PENALTY - 1);
        else if (w_squash) w_sq_nxt = r_sq - SQ_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex        <= CTRL_BUBBLE;
            r_mem       <= CTRL_BUBBLE;
            r_wb        <= CTRL_BUBBLE;
            r_sq        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // Squashed, stalled and redirecting instructions all enter EX as bubbles.
            r_ex  <= (w_squash || w_stall || w_redirect) ? CTRL_BUBBLE : w_dec;
            r_mem <= r_ex;
            r_wb  <= r_mem;
            r_sq  <= w_sq_nxt;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.if_flush   = 1'b0;
        bus.pc_sel     = PC_SEQ;
        if (reset) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.if_flush   = 1'b1;
        end else if (w_stall) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
        end else if (w_flush) begin
            bus.if_flush = 1'b1;
            if (w_redirect) bus.pc_sel = (w_class == J) ? PC_JUMP : PC_BRANCH;
        end
    end

    assign bus.alu_op_ex     = r_ex.alu_op;
    assign bus.alu_src_ex    = r_ex.alu_src;
    assign bus.mem_read_ex   = r_ex.mem_read;
    assign bus.reg_write_ex  = r_ex.reg_write;
    assign bus.wreg_ex       = r_ex.wreg[REG_AW-1:0];
    assign bus.mem_read_mem  = r_mem.mem_read;
    assign bus.mem_write_mem = r_mem.mem_write;
    assign bus.reg_write_mem = r_mem.reg_write;
    assign bus.wreg_mem      = r_mem.wreg[REG_AW-1:0];
    assign bus.reg_write_wb  = r_wb.reg_write;
    assign bus.mem_to_reg_wb = r_wb.mem_to_reg;
    assign bus.wreg_wb       = r_wb.wreg[REG_AW-1:0];
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;

    // Fields carried for uniformity of the stage registers but not needed
    // downstream.
    logic w_unused;
    assign w_unused = ^{r_mem.alu_op, r_mem.alu_src, r_wb.alu_op, r_wb.alu_src,
                        r_wb.mem_read, r_wb.mem_write, r_wb.wreg};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed sequences from the test plan followed
// by random instruction streams, checked cycle by cycle against a
// behavioural model of the pipeline held in this file.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int BP     = 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .BRANCH_PENALTY(BP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model of one instruction's effect, derived from the decode table.
    typedef struct {
        int dst;
        bit wr, mr, mw, m2r, asrc;
        int aop;
        bit use_rs, use_rt, is_beq, is_bne, is_j;
    } m_ins_t;

    typedef struct packed {
        logic              pcw, ifw, flush;
        logic [1:0]        sel;
        logic [1:0]        aop;
        logic              asrc, mr_ex, rw_ex;
        logic [REG_AW-1:0] w_ex;
        logic              mr_mem, mw_mem, rw_mem;
        logic [REG_AW-1:0] w_mem;
        logic              rw_wb, m2r_wb;
        logic [REG_AW-1:0] w_wb;
        logic [CNT_W-1:0]  scnt, fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    m_ins_t m_ex, m_mem, m_wb;
    int     m_sq, m_stalls, m_flushes;
    bit     m_stall_last;

    function automatic m_ins_t m_bubble();
        m_ins_t m;
        m = '{default: 0};
        return m;
    endfunction

    function automatic m_ins_t m_decode(input int op, input int rt, input int rd);
        m_ins_t m;
        m = '{default: 0};
        case (op)
            0:              begin m.aop = 2; m.wr = 1; m.dst = rd; m.use_rt = 1; end
            8, 10, 12, 13, 15: begin m.aop = 3; m.asrc = 1; m.wr = 1; m.dst = rt; end
            35:             begin m.asrc = 1; m.mr = 1; m.wr = 1; m.m2r = 1; m.dst = rt; end
            43:             begin m.asrc = 1; m.mw = 1; m.use_rt = 1; end
            4:              begin m.aop = 1; m.use_rt = 1; m.is_beq = 1; end
            5:              begin m.aop = 1; m.use_rt = 1; m.is_bne = 1; end
            2:              m.is_j = 1;
            default: ;
        endcase
        m.use_rs = (op != 2);
        if (m.dst == 0) m.wr = 0;
        return m;
    endfunction

    task automatic model_clear();
        m_ex = m_bubble(); m_mem = m_bubble(); m_wb = m_bubble();
        m_sq = 0; m_stalls = 0; m_flushes = 0; m_stall_last = 0;
    endtask

    // One cycle: drive ID inputs, push the expected outputs for this cycle,
    // then advance the model across the coming clock edge.
    task automatic step(input int op, input int rs, input int rt, input int rd,
                        input bit eq, input bit rst);
        m_ins_t d;
        bit squash, lu, bh, stall, taken, redir, flush;
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode_id = 6'(op);
        bus.rs_id     = REG_AW'(rs);
        bus.rt_id     = REG_AW'(rt);
        bus.rd_id     = REG_AW'(rd);
        bus.equal_id  = eq;

        d      = m_decode(op, rt, rd);
        squash = (m_sq > 0);
        lu     = m_ex.mr && (m_ex.dst != 0) &&
                 ((d.use_rs && m_ex.dst == rs) || (d.use_rt && m_ex.dst == rt));
        bh     = (d.is_beq || d.is_bne) &&
                 ((m_ex.wr && (m_ex.dst == rs || m_ex.dst == rt)) ||
                  (m_mem.mr && (m_mem.dst == rs || m_mem.dst == rt)));
        stall  = !squash && (lu || bh);
        taken  = (d.is_beq && eq) || (d.is_bne && !eq) || d.is_j;
        redir  = !squash && !stall && taken;
        flush  = squash || redir;

        e.pcw    = !rst && !stall;
        e.ifw    = !rst && !stall;
        e.flush  = rst || flush;
        e.sel    = (rst || !redir) ? 2'd0 : (d.is_j ? 2'd2 : 2'd1);
        e.aop    = 2'(m_ex.aop);
        e.asrc   = m_ex.asrc;
        e.mr_ex  = m_ex.mr;
        e.rw_ex  = m_ex.wr;
        e.w_ex   = REG_AW'(m_ex.dst);
        e.mr_mem = m_mem.mr;
        e.mw_mem = m_mem.mw;
        e.rw_mem = m_mem.wr;
        e.w_mem  = REG_AW'(m_mem.dst);
        e.rw_wb  = m_wb.wr;
        e.m2r_wb = m_wb.m2r;
        e.w_wb   = REG_AW'(m_wb.dst);
        e.scnt   = CNT_W'(m_stalls);
        e.fcnt   = CNT_W'(m_flushes);
        exp_q.push_back(e);

        if (rst) begin
            model_clear();
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (squash || stall || redir) ? m_bubble() : d;
            if (stall && m_stalls < CMAX) m_stalls++;
            if (flush && m_flushes < CMAX) m_flushes++;
            if (redir) m_sq = BP - 1;
            else if (squash) m_sq--;
            m_stall_last = stall;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
            miscompares++;
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            chk("pc_write",      32'(bus.pc_write),      32'(mon_e.pcw));
            chk("ifid_write",    32'(bus.ifid_write),    32'(mon_e.ifw));
            chk("if_flush",      32'(bus.if_flush),      32'(mon_e.flush));
            chk("pc_sel",        32'(bus.pc_sel),        32'(mon_e.sel));
            chk("alu_op_ex",     32'(bus.alu_op_ex),     32'(mon_e.aop));
            chk("alu_src_ex",    32'(bus.alu_src_ex),    32'(mon_e.asrc));
            chk("mem_read_ex",   32'(bus.mem_read_ex),   32'(mon_e.mr_ex));
            chk("reg_write_ex",  32'(bus.reg_write_ex),  32'(mon_e.rw_ex));
            chk("wreg_ex",       32'(bus.wreg_ex),       32'(mon_e.w_ex));
            chk("mem_read_mem",  32'(bus.mem_read_mem),  32'(mon_e.mr_mem));
            chk("mem_write_mem", 32'(bus.mem_write_mem), 32'(mon_e.mw_mem));
            chk("reg_write_mem", 32'(bus.reg_write_mem), 32'(mon_e.rw_mem));
            chk("wreg_mem",      32'(bus.wreg_mem),      32'(mon_e.w_mem));
            chk("reg_write_wb",  32'(bus.reg_write_wb),  32'(mon_e.rw_wb));
            chk("mem_to_reg_wb", 32'(bus.mem_to_reg_wb), 32'(mon_e.m2r_wb));
            chk("wreg_wb",       32'(bus.wreg_wb),       32'(mon_e.w_wb));
            chk("stall_cnt",     32'(bus.stall_cnt),     32'(mon_e.scnt));
            chk("flush_cnt",     32'(bus.flush_cnt),     32'(mon_e.fcnt));
        end
    end

    int ops [13] = '{0, 8, 10, 12, 13, 15, 35, 43, 4, 5, 2, 63, 0};

    initial begin
        int op, rs, rt, rd;
        bit eq;
        reset = 1'b1;
        bus.opcode_id = '0; bus.rs_id = '0; bus.rt_id = '0; bus.rd_id = '0;
        bus.equal_id = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();

        // Reset cycle, then load-use: lw r2 ; add r3,r2,r4 (held while stalled)
        step(63, 0, 0, 0, 0, 1);
        step(35, 1, 2, 0, 0, 0);
        step(0, 2, 4, 3, 0, 0);
        step(0, 2, 4, 3, 0, 0);
        step(63, 0, 0, 0, 0, 0);
        // lw r0 ; add r3,r0,r1 -> no stall
        step(35, 1, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        step(63, 0, 0, 0, 0, 0);
        // Taken beq, then bne arrivals during the squash are ignored
        step(4, 1, 2, 0, 1, 0);
        step(5, 1, 2, 0, 0, 0);
        step(5, 1, 2, 0, 0, 0);
        step(63, 0, 0, 0, 0, 0);
        // add r5 ; beq r5,r6 -> one stall, then not taken
        step(0, 1, 2, 5, 0, 0);
        step(4, 5, 6, 0, 0, 0);
        step(4, 5, 6, 0, 0, 0);
        // lw r5 ; beq r5,r6 -> two stalls, then taken
        step(35, 1, 5, 0, 0, 0);
        step(4, 5, 6, 0, 1, 0);
        step(4, 5, 6, 0, 1, 0);
        step(4, 5, 6, 0, 1, 0);
        step(63, 0, 0, 0, 0, 0);
        step(63, 0, 0, 0, 0, 0);
        // Illegal opcode, then lw r7 drained through WB
        step(63, 3, 3, 3, 0, 0);
        step(35, 1, 7, 0, 0, 0);
        repeat (4) step(63, 0, 0, 0, 0, 0);
        // Reset during a jump squash, then normal fetch
        step(2, 0, 0, 0, 0, 0);
        step(0, 1, 2, 3, 0, 0);
        step(0, 1, 2, 3, 0, 1);
        step(0, 1, 2, 3, 0, 1);
        step(0, 1, 2, 3, 0, 0);
        step(8, 1, 4, 0, 0, 0);

        // Random streams; a stalled instruction is held in ID like a real front end.
        op = 0; rs = 0; rt = 0; rd = 0; eq = 0;
        for (int i = 0; i < 600; i++) begin
            if (!m_stall_last) begin
                op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63))
                                                  : ops[$urandom_range(0, 12)];
                rs = $urandom_range(0, 7);
                rt = $urandom_range(0, 7);
                rd = $urandom_range(0, 7);
            end
            eq = 1'($urandom_range(0, 1));
            step(op, rs, rt, rd, eq, ($urandom_range(0, 79) == 0));
        end
        step(63, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
